emap_gather_ctrl: RTL and testbench

Sequencer for the 16-wide vector-element gather datapath (the Emap stage of the SpMV pipeline). It accepts one sparse-row job at a time: base address of the row's column-index words plus the number of 16-element chunks. It then fetches one index word per chunk, pulses the gather datapath's start input per chunk, and produces `out_valid`/`out_last` aligned with the datapath's `output_row`. Issue is throttled by a credit counter so the downstream multiplier FIFO never overflows.

---
 rtl/emap_pkg.sv | 18 +
 rtl/emap_valid_pipe.sv | 57 +++++
 rtl/emap_gather_ctrl.sv | 157 +++++++++++++++
 tb/tb_emap_gather_ctrl.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/emap_pkg.sv
// Shared types and constants for the Emap gather sequencer and its datapath.
package emap_pkg;

  // Sequencer states.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  localparam int unsigned DEF_GATHER_LAT     = 2;
  localparam int unsigned DEF_CREDITS        = 4;
  localparam int unsigned DEF_NO_OF_ELEMENTS = 16;

  // Column index value marking an unused lane; the datapath treats it as "no element".
  localparam logic [31:0] INVALID_COL = 32'hFFFF_FFFF;

endpackage : emap_pkg

// File: rtl/emap_valid_pipe.sv
// Fixed-latency delay line carrying {valid, last} alongside the gather datapath.
// `pending` reports valid bits in every stage except the output stage, so a
// consumer can tell that the chunk currently at the output is the final one.
module emap_valid_pipe #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic in_valid,
  input  logic in_last,
  output logic out_valid,
  output logic out_last,
  output logic pending
);

  logic [DEPTH-1:0] valid_q, valid_d;
  logic [DEPTH-1:0] last_q,  last_d;

  // Shift one stage per cycle; clear wipes every stage so no stale chunk escapes.
  always_comb begin
    // NOTE: every signal written here gets a value on every path, otherwise a latch is inferred.
    valid_d[0] = in_valid;
    last_d[0]  = in_last;
    for (int i = 1; i < DEPTH; i++) begin
      valid_d[i] = valid_q[i-1];
      last_d[i]  = last_q[i-1];
    end
    if (clr) begin
      valid_d = '0;
      last_d  = '0;
    end
  end

  // Any chunk still in flight ahead of the output stage.
  always_comb begin
    pending = 1'b0;
    for (int i = 0; i < DEPTH - 1; i++) begin
      pending = pending | valid_q[i];
    end
  end

  // Stage registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      last_q  <= '0;
    end else begin
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

  assign out_valid = valid_q[DEPTH-1];
  assign out_last  = last_q[DEPTH-1];

endmodule : emap_valid_pipe

// File: rtl/emap_gather_ctrl.sv
// Job sequencer for the 16-wide gather datapath: fetches one index word per
// chunk under credit control, pulses gather_start per chunk and tags the
// datapath output with out_valid/out_last.
module emap_gather_ctrl
  import emap_pkg::*;
#(
  parameter int unsigned NO_OF_ELEMENTS_IN_OUTPUT = DEF_NO_OF_ELEMENTS,
  parameter int unsigned IDX_ADDR_W               = 16,
  parameter int unsigned CNT_W                    = 32,
  parameter int unsigned GATHER_LAT               = DEF_GATHER_LAT,
  parameter int unsigned CREDITS                  = DEF_CREDITS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  job_valid,
  output logic                  job_ready,
  input  logic [IDX_ADDR_W-1:0] job_base,
  input  logic [CNT_W-1:0]      job_multiples,
  output logic                  idx_rd_en,
  output logic [IDX_ADDR_W-1:0] idx_rd_addr,
  output logic                  gather_start,
  output logic                  out_valid,
  output logic                  out_last,
  input  logic                  credit_return,
  input  logic                  abort,
  output logic                  job_done,
  output logic                  credit_err
);

  localparam int unsigned     CRED_W   = $clog2(CREDITS + 1);
  localparam logic [CRED_W-1:0] CRED_MAX = CRED_W'(CREDITS);

  // The index word holds one 32-bit column per element; the chunk counter must
  // be able to address every index word.
  if (NO_OF_ELEMENTS_IN_OUTPUT != DEF_NO_OF_ELEMENTS || CNT_W < IDX_ADDR_W || GATHER_LAT < 1)
  begin : g_param_check
    $error("emap_gather_ctrl: unsupported parameter combination");
  end

  state_e                state_q, state_d;
  logic [IDX_ADDR_W-1:0] base_q, base_d;
  logic [CNT_W-1:0]      mult_q, mult_d;
  logic [CNT_W-1:0]      k_q, k_d;
  logic [CRED_W-1:0]     credits_q, credits_d;
  logic                  start_q, start_d;
  logic                  start_last_q, start_last_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;

  logic issue;
  logic last_issue;
  logic ret_ok;
  logic pipe_pending;

  // One index fetch per cycle while issuing and a downstream slot is free.
  assign issue      = (state_q == S_ISSUE) && (credits_q != '0);
  assign last_issue = issue && ((k_q + CNT_W'(1)) == mult_q);
  // A return at full credit only counts when an issue consumes a slot in the same cycle.
  assign ret_ok     = credit_return && ((credits_q != CRED_MAX) || issue);

  // Next-state, credit and tag computation; abort overrides everything.
  always_comb begin
    state_d      = state_q;
    base_d       = base_q;
    mult_d       = mult_q;
    k_d          = k_q + CNT_W'(issue);
    credits_d    = credits_q - CRED_W'(issue) + CRED_W'(ret_ok);
    start_d      = issue;
    start_last_d = last_issue;
    done_d       = 1'b0;
    err_d        = err_q | (credit_return && (credits_q == CRED_MAX) && !issue);

    case (state_q)
      S_IDLE: begin
        if (job_valid) begin
          base_d = job_base;
          mult_d = job_multiples;
          k_d    = '0;
          if (job_multiples == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        if (last_issue) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        // Done once only the final chunk (at the pipe output) remains.
        if (!start_q && !pipe_pending) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (abort) begin
      state_d      = S_IDLE;
      base_d       = base_q;
      mult_d       = mult_q;
      k_d          = k_q;
      credits_d    = CRED_MAX;
      start_d      = 1'b0;
      start_last_d = 1'b0;
      done_d       = 1'b0;
    end
  end

  // Sequencer state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      base_q       <= '0;
      mult_q       <= '0;
      k_q          <= '0;
      credits_q    <= CRED_MAX;
      start_q      <= 1'b0;
      start_last_q <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q      <= state_d;
      base_q       <= base_d;
      mult_q       <= mult_d;
      k_q          <= k_d;
      credits_q    <= credits_d;
      start_q      <= start_d;
      start_last_q <= start_last_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  emap_valid_pipe #(
    .DEPTH (int'(GATHER_LAT))
  ) u_valid_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (abort),
    .in_valid  (start_q),
    .in_last   (start_last_q),
    .out_valid (out_valid),
    .out_last  (out_last),
    .pending   (pipe_pending)
  );

  assign job_ready    = (state_q == S_IDLE);
  assign idx_rd_en    = issue;
  assign idx_rd_addr  = base_q + IDX_ADDR_W'(k_q);
  assign gather_start = start_q;
  assign job_done     = done_q;
  assign credit_err   = err_q;

endmodule : emap_gather_ctrl

// File: tb/tb_emap_gather_ctrl.sv
// Self-checking bench for emap_gather_ctrl: directed job table, hand-written
// abort / credit-error / reset sequences, and a randomized run against a
// schedule-based reference model.
module tb_emap_gather_ctrl;

  localparam int LAT     = 2;
  localparam int CREDITS = 4;
  localparam int NC      = 1500;
  localparam int NT      = NC + 20;
  localparam int INF     = 32'h7fff_ffff;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        job_valid = 1'b0;
  logic        job_ready;
  logic [15:0] job_base = '0;
  logic [31:0] job_multiples = '0;
  logic        idx_rd_en;
  logic [15:0] idx_rd_addr;
  logic        gather_start;
  logic        out_valid;
  logic        out_last;
  logic        credit_return = 1'b0;
  logic        abort = 1'b0;
  logic        job_done;
  logic        credit_err;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  emap_gather_ctrl #(
    .NO_OF_ELEMENTS_IN_OUTPUT (16),
    .IDX_ADDR_W               (16),
    .CNT_W                    (32),
    .GATHER_LAT               (LAT),
    .CREDITS                  (CREDITS)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .job_valid     (job_valid),
    .job_ready     (job_ready),
    .job_base      (job_base),
    .job_multiples (job_multiples),
    .idx_rd_en     (idx_rd_en),
    .idx_rd_addr   (idx_rd_addr),
    .gather_start  (gather_start),
    .out_valid     (out_valid),
    .out_last      (out_last),
    .credit_return (credit_return),
    .abort         (abort),
    .job_done      (job_done),
    .credit_err    (credit_err)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n         = 1'b0;
    job_valid     = 1'b0;
    job_base      = '0;
    job_multiples = '0;
    credit_return = 1'b0;
    abort         = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Directed job table: one job per row from a fresh reset.
  typedef struct {
    logic [15:0] base;
    logic [31:0] mult;
    int          ret_from;     // cycle after acceptance when returns start, -1 = none
    int          ret_cnt;      // consecutive return cycles
    int          exp_reads;
    int          exp_outs;
    int          exp_lasts;
    int          exp_done_off; // job_done cycle relative to acceptance
    int          exp_credits;  // credit count at end of window
  } vec_t;

  vec_t vecs [5];

  // Reference model state for the randomized run.
  bit          e_start [NT+16];
  bit          e_valid [NT+16];
  bit          e_last  [NT+16];
  bit          e_done  [NT+16];
  int          m_cred;
  bit          m_err;
  bit          m_active;
  int          m_k;
  int          m_mult;
  logic [15:0] m_base;
  int          m_done_cyc;
  bit          m_issue;
  bit          exp_ready;
  logic [15:0] exp_addr;

  int n_rd, n_st, n_ov, n_ol, n_dn, n_pre, n_post;
  int first_rd, first_st, first_ov, first_dn;
  logic [15:0] ea;
  bit jv, cr;
  logic [15:0] jb;
  int jm;

  initial begin
    vecs[0] = '{16'h0010, 32'd3, -1, 0, 3, 3, 1, 7,  1};
    vecs[1] = '{16'h0100, 32'd6, 10, 6, 6, 6, 1, 16, 4};
    vecs[2] = '{16'h0055, 32'd0, -1, 0, 0, 0, 0, 1,  4};
    vecs[3] = '{16'hFFFE, 32'd4, -1, 0, 4, 4, 1, 8,  0};
    vecs[4] = '{16'h1234, 32'd1, -1, 0, 1, 1, 1, 5,  3};

    // ---------------- reset values ----------------
    do_reset();
    check("rst job_ready",    64'(job_ready),    64'd1);
    check("rst idx_rd_en",    64'(idx_rd_en),    64'd0);
    check("rst idx_rd_addr",  64'(idx_rd_addr),  64'd0);
    check("rst gather_start", 64'(gather_start), 64'd0);
    check("rst out_valid",    64'(out_valid),    64'd0);
    check("rst out_last",     64'(out_last),     64'd0);
    check("rst job_done",     64'(job_done),     64'd0);
    check("rst credit_err",   64'(credit_err),   64'd0);
    check("rst credits",      64'(dut.credits_q), 64'(CREDITS));

    // ---------------- directed job table ----------------
    for (int r = 0; r < 5; r++) begin
      do_reset();
      n_rd = 0; n_st = 0; n_ov = 0; n_ol = 0; n_dn = 0;
      first_rd = -1; first_st = -1; first_ov = -1; first_dn = -1;
      for (int t = 0; t < 40; t++) begin
        job_valid     = (t == 0);
        job_base      = vecs[r].base;
        job_multiples = vecs[r].mult;
        credit_return = (vecs[r].ret_from >= 0) && (t >= vecs[r].ret_from) &&
                        (t < vecs[r].ret_from + vecs[r].ret_cnt);
        @(negedge clk);
        if (t == 0) check($sformatf("row%0d ready", r), 64'(job_ready), 64'd1);
        if (idx_rd_en) begin
          ea = vecs[r].base + 16'(n_rd);
          check($sformatf("row%0d addr%0d", r, n_rd), 64'(idx_rd_addr), 64'(ea));
          if (first_rd < 0) first_rd = t;
          n_rd++;
        end
        if (gather_start) begin
          if (first_st < 0) first_st = t;
          n_st++;
        end
        if (out_valid) begin
          if (first_ov < 0) first_ov = t;
          n_ov++;
        end
        if (out_last) n_ol++;
        if (job_done) begin
          if (first_dn < 0) first_dn = t;
          n_dn++;
        end
        next_cycle();
      end
      credit_return = 1'b0;
      check($sformatf("row%0d reads", r),    64'(n_rd),     64'(vecs[r].exp_reads));
      check($sformatf("row%0d starts", r),   64'(n_st),     64'(vecs[r].exp_reads));
      check($sformatf("row%0d outs", r),     64'(n_ov),     64'(vecs[r].exp_outs));
      check($sformatf("row%0d lasts", r),    64'(n_ol),     64'(vecs[r].exp_lasts));
      check($sformatf("row%0d done_off", r), 64'(first_dn), 64'(vecs[r].exp_done_off));
      check($sformatf("row%0d done_cnt", r), 64'(n_dn),     64'd1);
      check($sformatf("row%0d credits", r),  64'(dut.credits_q), 64'(vecs[r].exp_credits));
      if (vecs[r].exp_reads > 0) begin
        check($sformatf("row%0d first_rd", r), 64'(first_rd), 64'd1);
        check($sformatf("row%0d first_st", r), 64'(first_st), 64'd2);
        check($sformatf("row%0d first_ov", r), 64'(first_ov), 64'(2 + LAT));
      end else begin
        check($sformatf("row%0d no_rd", r), 64'(first_rd + 1), 64'd0);
      end
    end

    // ---------------- abort on the 2nd issue cycle ----------------
    do_reset();
    n_pre = 0; n_post = 0; n_ov = 0; n_dn = 0;
    for (int t = 0; t < 23; t++) begin
      job_valid     = (t == 0);
      job_base      = 16'h0020;
      job_multiples = 32'd8;
      abort         = (t == 2);
      @(negedge clk);
      if (idx_rd_en) begin
        if (t <= 2) n_pre++;
        else        n_post++;
      end
      if (out_valid) n_ov++;
      if (job_done)  n_dn++;
      next_cycle();
    end
    abort = 1'b0;
    check("abort pre_reads",  64'(n_pre),  64'd2);
    check("abort post_reads", 64'(n_post), 64'd0);
    check("abort outs",       64'(n_ov),   64'd0);
    check("abort done",       64'(n_dn),   64'd0);
    check("abort credits",    64'(dut.credits_q), 64'(CREDITS));
    check("abort ready",      64'(job_ready), 64'd1);

    n_ov = 0; n_ol = 0; first_dn = -1;
    for (int t = 0; t < 12; t++) begin
      job_valid     = (t == 0);
      job_base      = 16'h0040;
      job_multiples = 32'd1;
      @(negedge clk);
      if (out_valid) n_ov++;
      if (out_last)  n_ol++;
      if (job_done && first_dn < 0) first_dn = t;
      next_cycle();
    end
    check("post_abort outs",     64'(n_ov),     64'd1);
    check("post_abort lasts",    64'(n_ol),     64'd1);
    check("post_abort done_off", 64'(first_dn), 64'd5);

    // ---------------- abort together with job_valid in IDLE ----------------
    n_rd = 0;
    for (int t = 0; t < 6; t++) begin
      job_valid     = (t == 0);
      abort         = (t == 0);
      job_multiples = 32'd2;
      @(negedge clk);
      if (t == 1) check("abort_accept ready", 64'(job_ready), 64'd1);
      if (idx_rd_en) n_rd++;
      next_cycle();
    end
    abort = 1'b0;
    check("abort_accept reads", 64'(n_rd), 64'd0);

    // ---------------- credit error, sticky ----------------
    do_reset();
    credit_return = 1'b1;
    next_cycle();
    credit_return = 1'b0;
    @(negedge clk);
    check("credit_err set", 64'(credit_err), 64'd1);
    repeat (4) next_cycle();
    @(negedge clk);
    check("credit_err sticky",   64'(credit_err),     64'd1);
    check("credit_err credits",  64'(dut.credits_q),  64'(CREDITS));
    next_cycle();

    // ---------------- async reset mid-job ----------------
    for (int t = 0; t < 6; t++) begin
      job_valid     = (t == 0);
      job_base      = 16'h0300;
      job_multiples = 32'd8;
      @(negedge clk);
      if (t < 5) next_cycle();
    end
    job_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midrst job_ready",    64'(job_ready),    64'd1);
    check("midrst idx_rd_en",    64'(idx_rd_en),    64'd0);
    check("midrst idx_rd_addr",  64'(idx_rd_addr),  64'd0);
    check("midrst gather_start", 64'(gather_start), 64'd0);
    check("midrst out_valid",    64'(out_valid),    64'd0);
    check("midrst out_last",     64'(out_last),     64'd0);
    check("midrst job_done",     64'(job_done),     64'd0);
    check("midrst credit_err",   64'(credit_err),   64'd0);
    check("midrst credits",      64'(dut.credits_q), 64'(CREDITS));

    // ---------------- randomized run vs. schedule model ----------------
    do_reset();
    for (int i = 0; i < NT + 16; i++) begin
      e_start[i] = 1'b0; e_valid[i] = 1'b0; e_last[i] = 1'b0; e_done[i] = 1'b0;
    end
    m_cred = CREDITS; m_err = 1'b0; m_active = 1'b0; m_k = 0; m_mult = 0;
    m_base = '0; m_done_cyc = 0;
    for (int c = 0; c < NT; c++) begin
      jv = (c < NC) && ($urandom_range(0, 1) == 1);
      jb = 16'($urandom);
      jm = int'($urandom_range(0, 6));
      cr = ($urandom_range(0, 3) == 0);
      job_valid     = jv;
      job_base      = jb;
      job_multiples = 32'(jm);
      credit_return = cr;
      @(negedge clk);

      exp_ready = (c >= m_done_cyc);
      m_issue   = m_active && (m_cred > 0);
      exp_addr  = m_base + 16'(m_k);
      check($sformatf("rnd c%0d ready", c),  64'(job_ready),    64'(exp_ready));
      check($sformatf("rnd c%0d rd_en", c),  64'(idx_rd_en),    64'(m_issue));
      if (m_issue) check($sformatf("rnd c%0d addr", c), 64'(idx_rd_addr), 64'(exp_addr));
      check($sformatf("rnd c%0d start", c),  64'(gather_start), 64'(e_start[c]));
      check($sformatf("rnd c%0d valid", c),  64'(out_valid),    64'(e_valid[c]));
      check($sformatf("rnd c%0d last", c),   64'(out_last),     64'(e_last[c]));
      check($sformatf("rnd c%0d done", c),   64'(job_done),     64'(e_done[c]));
      check($sformatf("rnd c%0d err", c),    64'(credit_err),   64'(m_err));

      // Chunk issued now: start next cycle, output LAT cycles after that.
      if (m_issue) begin
        e_start[c+1]       = 1'b1;
        e_valid[c+1+LAT]   = 1'b1;
        if (m_k == m_mult - 1) begin
          e_last[c+1+LAT] = 1'b1;
          e_done[c+2+LAT] = 1'b1;
          m_done_cyc      = c + 2 + LAT;
          m_active        = 1'b0;
        end
        m_k++;
      end
      if (cr) begin
        if (m_cred == CREDITS && !m_issue) m_err = 1'b1;
        else                               m_cred++;
      end
      if (m_issue) m_cred--;
      if (jv && exp_ready) begin
        if (jm == 0) begin
          e_done[c+1] = 1'b1;
          m_done_cyc  = c + 1;
        end else begin
          m_active   = 1'b1;
          m_k        = 0;
          m_mult     = jm;
          m_base     = jb;
          m_done_cyc = INF;
        end
      end
      next_cycle();
    end
    job_valid     = 1'b0;
    credit_return = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_emap_gather_ctrl
